// File: rtl/token_rmw_writer.sv
// Token placement engine: reads three board rows, checks the chosen shape for
// overlap and range, then paints or erases it with a read-modify-write.
module token_rmw_writer #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int ADDR_W = 5,
    parameter int CX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        tok_id,
    input  logic [1:0]        mode,
    input  logic [CX_W-1:0]   col_x,
    input  logic [ADDR_W-1:0] row_base,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COLS-1:0]   rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COLS-1:0]   wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RD,
        S_CAP,
        S_EVAL,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0]        MODE_PAINT = 2'b00;
    localparam logic [1:0]        MODE_ERASE = 2'b01;
    localparam logic [CX_W-1:0]   COL_MAX    = CX_W'(COLS - 3);
    localparam logic [ADDR_W-1:0] ROW_MAX    = ADDR_W'(ROWS - 3);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q;
    logic [2:0]          tok_q;
    logic [1:0]          mode_q;
    logic [CX_W-1:0]     col_x_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic [COLS-1:0]     buf_q [3];
    logic                range_bad;
    logic                hit;
    logic [COLS-1:0]     cur_mask;
    logic [ADDR_W-1:0]   cur_addr;

    // Packed as {row2, row1, row0}; bit k of a row lands on column col_x+k.
    function automatic logic [2:0] shape_row(input logic [2:0] tok, input logic [1:0] r);
        logic [8:0] s;
        case (tok)
            3'd0:    s = {3'b011, 3'b011, 3'b000};
            3'd1:    s = {3'b011, 3'b010, 3'b010};
            3'd2:    s = {3'b111, 3'b010, 3'b000};
            3'd3:    s = {3'b001, 3'b011, 3'b010};
            3'd4:    s = {3'b000, 3'b111, 3'b000};
            3'd5:    s = {3'b010, 3'b010, 3'b010};
            3'd6:    s = {3'b011, 3'b110, 3'b000};
            default: s = {3'b110, 3'b011, 3'b000};
        endcase
        case (r)
            2'd0:    return s[2:0];
            2'd1:    return s[5:3];
            default: return s[8:6];
        endcase
    endfunction

    function automatic logic [COLS-1:0] row_mask(input logic [2:0] tok, input logic [1:0] r,
                                                 input logic [CX_W-1:0] cx);
        return COLS'(shape_row(tok, r)) << cx;
    endfunction

    assign range_bad = (col_x_q > COL_MAX) || (row_base_q > ROW_MAX);
    assign cur_mask  = row_mask(tok_q, cnt_q, col_x_q);
    assign cur_addr  = row_base_q + ADDR_W'(cnt_q);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hit = hit | (|(buf_q[i] & row_mask(tok_q, 2'(i), col_x_q)));
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CHK;
            S_CHK:  state_d = range_bad ? S_DONE : S_RD;
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = (cnt_q == 2'd2) ? S_EVAL : S_RD;
            S_EVAL: begin
                if (mode_q[1] || (mode_q == MODE_PAINT && hit))
                    state_d = S_DONE;
                else
                    state_d = S_WR;
            end
            S_WR:   state_d = (cnt_q == 2'd2) ? S_DONE : S_WR;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            tok_q      <= 3'd0;
            mode_q     <= 2'd0;
            col_x_q    <= '0;
            row_base_q <= '0;
            collision  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tok_q      <= tok_id;
                        mode_q     <= mode;
                        col_x_q    <= col_x;
                        row_base_q <= row_base;
                        cnt_q      <= 2'd0;
                        collision  <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                S_CHK:  err <= range_bad;
                S_CAP,
                S_WR:   cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
                S_EVAL: collision <= hit;
                default: ;
            endcase
        end
    end

    // NOTE: the row buffer is pure datapath, always refilled before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_CAP) buf_q[cnt_q] <= rd_data;
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        rd_en   = (state_q == S_RD);
        wr_en   = (state_q == S_WR);
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        if (rd_en) rd_addr = cur_addr;
        if (wr_en) begin
            wr_addr = cur_addr;
            if (mode_q == MODE_ERASE)
                wr_data = buf_q[cnt_q] & ~cur_mask;
            else
                wr_data = buf_q[cnt_q] | cur_mask;
        end
    end

endmodule

// File: tb/tb_token_rmw_writer.sv
// Directed bench for token_rmw_writer: behavioural row RAM, write scoreboard,
// latency/flag checks and a reset-during-write scenario.
module tb_token_rmw_writer;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int ADDR_W = 5;
    localparam int CX_W   = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [2:0]        tok_id;
    logic [1:0]        mode;
    logic [CX_W-1:0]   col_x;
    logic [ADDR_W-1:0] row_base;
    logic              busy, done, collision, err;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [COLS-1:0]   rd_data, wr_data;

    logic [COLS-1:0]   mem [32];
    logic              tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [COLS-1:0]   tb_din;

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [ADDR_W+COLS-1:0] exp_q [$];

    token_rmw_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CX_W(CX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .tok_id(tok_id), .mode(mode),
        .col_x(col_x), .row_base(row_base), .busy(busy), .done(done),
        .collision(collision), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row RAM: one-cycle read latency; the bench backdoor port preloads rows.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (tb_we) mem[tb_addr] <= tb_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) rd_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() > 0) begin
                    logic [ADDR_W+COLS-1:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+COLS-1:COLS]));
                    check("wr_data", 32'(wr_data), 32'(e[COLS-1:0]));
                end else begin
                    check("unexpected_wr", 32'(wr_en), 32'(0));
                end
            end
            if (busy) check("rd_wr_exclusive", 32'(rd_en & wr_en), 32'(0));
        end
    end

    function automatic logic [2:0] ref_row(input int tok, input int r);
        logic [2:0] rows [3];
        case (tok)
            0: rows = '{3'b000, 3'b011, 3'b011};
            1: rows = '{3'b010, 3'b010, 3'b011};
            2: rows = '{3'b000, 3'b010, 3'b111};
            3: rows = '{3'b010, 3'b011, 3'b001};
            4: rows = '{3'b000, 3'b111, 3'b000};
            5: rows = '{3'b010, 3'b010, 3'b010};
            6: rows = '{3'b000, 3'b110, 3'b011};
            default: rows = '{3'b000, 3'b011, 3'b110};
        endcase
        return rows[r];
    endfunction

    function automatic logic [COLS-1:0] ref_mask(input int tok, input int r, input int cx);
        return COLS'(ref_row(tok, r)) << cx;
    endfunction

    task automatic poke(input int addr, input logic [COLS-1:0] val);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = ADDR_W'(addr);
        tb_din  = val;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic clear_mem();
        for (int r = 0; r < ROWS; r++) poke(r, '0);
    endtask

    // Drives one operation, predicts its writes/flags/latency and checks them.
    task automatic run_op(input string name, input int tok, input int md, input int cx, input int rb);
        logic e_err, e_coll, e_wr;
        int   e_lat, cyc, busy_n;
        e_err  = (cx > COLS - 3) || (rb > ROWS - 3);
        e_coll = 1'b0;
        if (!e_err)
            for (int i = 0; i < 3; i++)
                if ((mem[rb+i] & ref_mask(tok, i, cx)) != '0) e_coll = 1'b1;
        e_wr  = !e_err && (md == 1 || (md == 0 && !e_coll));
        e_lat = e_err ? 2 : (e_wr ? 12 : 9);
        if (e_wr)
            for (int i = 0; i < 3; i++) begin
                logic [COLS-1:0] nv;
                nv = (md == 1) ? (mem[rb+i] & ~ref_mask(tok, i, cx)) : (mem[rb+i] | ref_mask(tok, i, cx));
                exp_q.push_back({ADDR_W'(rb + i), nv});
            end
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk);
        start    = 1'b1;
        tok_id   = 3'(tok);
        mode     = 2'(md);
        col_x    = CX_W'(cx);
        row_base = ADDR_W'(rb);
        @(posedge clk);
        #1 start = 1'b0;
        cyc    = 0;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (done) break;
        end
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_latency"}, 32'(cyc), 32'(e_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(e_lat));
        check({name, "_collision"}, 32'(collision), 32'(e_coll));
        check({name, "_err"}, 32'(err), 32'(e_err));
        @(negedge clk);
        check({name, "_idle"}, 32'({busy, done}), 32'(0));
        check({name, "_rd_count"}, 32'(rd_cnt), e_err ? 32'(0) : 32'(3));
        check({name, "_wr_count"}, 32'(wr_cnt), e_wr ? 32'(3) : 32'(0));
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; tok_id = '0; mode = '0; col_x = '0; row_base = '0;
        tb_we = 1'b0; tb_addr = '0; tb_din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({busy, done, collision, err, rd_en, wr_en}), 32'(0));
        check("rst_rd_addr", 32'(rd_addr), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        @(negedge clk) reset = 1'b0;
        clear_mem();

        run_op("paint_t0", 0, 0, 4, 0);
        check("t0_row0", 32'(mem[0]), 32'h000);
        check("t0_row1", 32'(mem[1]), 32'h030);
        check("t0_row2", 32'(mem[2]), 32'h030);

        run_op("paint_t2", 2, 0, 4, 5);
        check("t2_row5", 32'(mem[5]), 32'h000);
        check("t2_row6", 32'(mem[6]), 32'h020);
        check("t2_row7", 32'(mem[7]), 32'h070);

        run_op("chk_self", 2, 3, 4, 5);
        run_op("chk_free", 1, 2, 0, 3);

        run_op("edge_legal", 4, 0, 7, 17);
        check("edge_row18", 32'(mem[18]), 32'h380);

        clear_mem();
        poke(1, 10'h020);
        run_op("paint_abort", 0, 0, 4, 0);
        check("abort_row1", 32'(mem[1]), 32'h020);
        check("abort_row2", 32'(mem[2]), 32'h000);

        for (int r = 0; r < 3; r++) poke(r, 10'h3FF);
        run_op("erase_t3", 3, 1, 0, 0);
        check("erase_row0", 32'(mem[0]), 32'h3FD);
        check("erase_row1", 32'(mem[1]), 32'h3FC);
        check("erase_row2", 32'(mem[2]), 32'h3FE);

        run_op("err_col", 0, 0, 8, 0);
        run_op("err_row", 0, 0, 0, 18);

        // Second start while busy must be ignored; reset lands inside the second write.
        clear_mem();
        rd_cnt = 0;
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(10 + i), 10'h008});
        @(negedge clk);
        start = 1'b1; tok_id = 3'd5; mode = 2'd0; col_x = 4'd2; row_base = 5'd10;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; tok_id = 3'd4; col_x = 4'd0; row_base = 5'd0;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 5'd11) break;
        end
        check("rst_mid_wr_seen", 32'({wr_en, wr_addr}), 32'({1'b1, 5'd11}));
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({busy, done, wr_en, rd_en}), 32'(0));
        check("rst_mid_flags", 32'({collision, err}), 32'(0));
        check("rst_mid_sb_left", 32'(exp_q.size()), 32'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_wr_count", 32'(wr_cnt), 32'(2));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_row10", 32'(mem[10]), 32'h008);
        check("rst_mid_row11", 32'(mem[11]), 32'h000);
        check("rst_mid_row12", 32'(mem[12]), 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/token_rmw_writer.md
Name: token_rmw_writer

Overview:
- Parametrised successor to the fixed 3-row token painter.
- Places one of 8 token shapes into the board matrix memory at a runtime column and row, as a read-modify-write.
- Supports paint, erase and check-only modes, with collision and range checking and a start/busy/done handshake.
- Sits between the game-control FSM and the board row RAM; it owns the RAM read and write ports while busy.

Parameters:
- COLS, 10, board width in cells; equals the RAM row width.
- ROWS, 20, number of valid board rows.
- ADDR_W, 5, row address width.
- CX_W, 4, column index width; must satisfy 2^CX_W >= COLS.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- tok_id  in  3  token shape select
- mode  in  2  00 paint (OR), 01 erase (AND NOT), 10/11 check-only
- col_x  in  CX_W  board column of the shape's bit 0
- row_base  in  ADDR_W  board row of shape row 0
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  result flag, valid from done until next accepted start
- err  out  1  range error flag, same validity as collision
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read row
- rd_data  in  COLS  RAM read data, valid the cycle after rd_en
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write row
- wr_data  out  COLS  RAM write data

Behaviour:
- Reset: state IDLE; row counter 0. busy, done, collision, err, rd_en and wr_en are 0. rd_addr, wr_addr and wr_data are 0. Reset is honoured at any point, including mid-write; no further strobes follow.
- Shape ROM: 3 rows x 3 bits, listed as row0/row1/row2; bit k maps to board column col_x+k.
  - 0: 000/011/011
  - 1: 000/001/011 ... superseded below; use this table exactly:
  - 0: 000/011/011
  - 1: 010/010/011
  - 2: 000/010/111
  - 3: 010/011/001
  - 4: 000/111/000
  - 5: 010/010/010
  - 6: 000/110/011
  - 7: 000/011/110
- Shifted mask: 3-bit row zero-extended to COLS bits, then shifted left by col_x.
- Accept: start=1 in IDLE at an edge latches tok_id, mode, col_x and row_base, and clears collision and err. busy=1 from the next cycle through the DONE cycle inclusive. start while busy is ignored.
- Range check, evaluated in the cycle after accept: if col_x > COLS-3 or row_base > ROWS-3:
  - err=1;
  - go straight to DONE;
  - no rd_en or wr_en is issued.
- States: IDLE -> CHK -> RD -> CAP -> (RD while row counter < 2) -> EVAL -> WR x3 -> DONE -> IDLE.
- RD: rd_en=1, rd_addr=row_base+i.
- CAP: capture rd_data into buffer[i]; i increments.
- EVAL: collision = OR over i of (buffer[i] & mask[i]) != 0.
  - Paint with collision=1: skip WR, go to DONE, no writes.
  - Check-only: always skip WR.
  - Erase: collision is still computed and reported, but writes proceed.
- WR (i=0..2): wr_en=1, wr_addr=row_base+i.
  - wr_data = buffer[i] | mask[i] in paint.
  - wr_data = buffer[i] & ~mask[i] in erase.
  - Rows with an all-zero mask are still written back unchanged.
- DONE: done=1 for one cycle, then IDLE.
- Latency from the accept edge to the done cycle:
  - paint/erase with no abort: 12 cycles;
  - aborted paint or check-only: 9 cycles;
  - range error: 2 cycles.
- Outputs decode from registered state, the row counter and latched inputs. rd_en and wr_en are never high in the same cycle.
- Row addition is ADDR_W-bit. The range check guarantees no wrap for legal operations.

Test Plan:
- Empty RAM; paint tok 0, col_x=4, row_base=0 -> writes in order: row0=0x000, row1=0x030, row2=0x030. collision=0, err=0, done 12 cycles after accept.
- Empty RAM; paint tok 2, col_x=4, row_base=5 -> rows 5/6/7 = 0x000/0x020/0x070. busy stays high for 12 cycles.
- Pre-load row 1 = 0x020; paint tok 0, col_x=4, row_base=0 -> collision=1, wr_en never asserted, done 9 cycles after accept, RAM unchanged.
- RAM rows 0-2 = 0x3FF; erase tok 3, col_x=0 -> rows = 0x3FD/0x3FC/0x3FE, and collision=1 is reported.
- col_x=8 (COLS=10) or row_base=18 (ROWS=20) -> err=1, done 2 cycles after accept, no rd_en or wr_en.
- Pulse start while busy with a different tok_id -> ignored. Assert reset during the second WR cycle -> wr_en drops immediately, busy=0, and the third row is not written.
